// File: rtl/cpu_regfile_mp.sv
`timescale 1ns/1ps
// cpu_regfile_mp
// Multi-port CPU register file: two registered read ports, one write port,
// a program-counter port with auto-increment and a per-register scoreboard
// of pending writes. Register 0 always reads as zero.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes
// (and the PC increment) to the read ports. Without it, a read that
// coincides with a write to the same register returns the pre-write value.
module cpu_regfile_mp #(
  parameter int          DAT_WIDTH = 64,
  parameter int          REG_COUNT = 32,
  parameter int          PC_REG    = 31,
  parameter logic [63:0] PC_RESET  = 64'h800000000000,
  parameter int          PC_STEP   = 8,
  parameter int          ID_W      = $clog2(REG_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ra_en_i,
  input  logic [ID_W-1:0]      ra_id_i,
  output logic [DAT_WIDTH-1:0] ra_dat_o,
  output logic                 ra_vld_o,
  input  logic                 rb_en_i,
  input  logic [ID_W-1:0]      rb_id_i,
  output logic [DAT_WIDTH-1:0] rb_dat_o,
  output logic                 rb_vld_o,
  input  logic                 we_i,
  input  logic [ID_W-1:0]      wr_id_i,
  input  logic [DAT_WIDTH-1:0] wr_dat_i,
  output logic [DAT_WIDTH-1:0] pc_o,
  input  logic                 pc_inc_i,
  input  logic                 mark_i,
  input  logic [ID_W-1:0]      mark_id_i,
  output logic [REG_COUNT-1:0] pend_o
);

  localparam logic [DAT_WIDTH-1:0] PC_INIT = DAT_WIDTH'(PC_RESET);
  localparam logic [DAT_WIDTH-1:0] PC_INC  = DAT_WIDTH'(PC_STEP);
  localparam logic [ID_W-1:0]      PC_ID   = ID_W'(PC_REG);

  logic [DAT_WIDTH-1:0] regs   [REG_COUNT];
  logic [DAT_WIDTH-1:0] reg_wd [REG_COUNT];
  logic [REG_COUNT-1:0] reg_we;
  logic [REG_COUNT-1:0] pend;
  logic [REG_COUNT-1:0] pend_next;
  logic [DAT_WIDTH-1:0] pc_cur;
  logic [DAT_WIDTH-1:0] pc_plus;
  logic                 pc_write_hit;
  logic                 pc_inc_take;
  logic [DAT_WIDTH-1:0] ra_next;
  logic [DAT_WIDTH-1:0] rb_next;

  assign pc_cur = regs[PC_REG];
  assign pc_o   = pc_cur;
  assign pend_o = pend;

  // PC increment is suppressed whenever an explicit write targets the PC (a jump)
  always_comb begin
    pc_write_hit = we_i && (wr_id_i == PC_ID);
    pc_inc_take  = pc_inc_i && !pc_write_hit;
    pc_plus      = pc_cur + PC_INC;
  end

  // Per-register write enable and data; register 0 is never written
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      reg_we[i] = 1'b0;
      reg_wd[i] = wr_dat_i;
      if ((i != 0) && we_i && (wr_id_i == ID_W'(i))) begin
        reg_we[i] = 1'b1;
      end else if ((i == PC_REG) && pc_inc_take) begin
        reg_we[i] = 1'b1;
        reg_wd[i] = pc_plus;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read data selection with forwarding of this cycle's register update
  always_comb begin
    ra_next = '0;
    rb_next = '0;
    if (ra_id_i != '0) begin
      ra_next = reg_we[ra_id_i] ? reg_wd[ra_id_i] : regs[ra_id_i];
    end
    if (rb_id_i != '0) begin
      rb_next = reg_we[rb_id_i] ? reg_wd[rb_id_i] : regs[rb_id_i];
    end
  end
`else
  // Read data selection from current register state (pre-write values)
  always_comb begin
    ra_next = '0;
    rb_next = '0;
    if (ra_id_i != '0) begin
      ra_next = regs[ra_id_i];
    end
    if (rb_id_i != '0) begin
      rb_next = regs[rb_id_i];
    end
  end
`endif

  // Register storage: reset clears everything except the PC, which gets its boot value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == PC_REG) ? PC_INIT : '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (reg_we[i]) begin
          regs[i] <= reg_wd[i];
        end
      end
    end
  end

  // Read port A: one-cycle latency, data holds when the port is idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ra_dat_o <= '0;
      ra_vld_o <= 1'b0;
    end else begin
      ra_vld_o <= ra_en_i;
      if (ra_en_i) begin
        ra_dat_o <= ra_next;
      end
    end
  end

  // Read port B: identical to port A and fully independent of it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rb_dat_o <= '0;
      rb_vld_o <= 1'b0;
    end else begin
      rb_vld_o <= rb_en_i;
      if (rb_en_i) begin
        rb_dat_o <= rb_next;
      end
    end
  end

  // Scoreboard update: a write retires the pending bit, a mark of the same register re-arms it
  always_comb begin
    pend_next = pend;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (we_i && (wr_id_i == ID_W'(i))) begin
        pend_next[i] = 1'b0;
      end
      if ((i != 0) && mark_i && (mark_id_i == ID_W'(i))) begin
        pend_next[i] = 1'b1;
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
`timescale 1ns/1ps
// tb_cpu_regfile_mp
// Directed scenarios plus randomized traffic against a behavioural model of
// the register file. Build with +define+REGFILE_BYPASS_EN to check forwarding.
module tb_cpu_regfile_mp;

  localparam int          DW    = 64;
  localparam int          RC    = 32;
  localparam int          IW    = 5;
  localparam int          PCR   = 31;
  localparam logic [63:0] PCRST = 64'h800000000000;
  localparam int          STEP  = 8;

  logic          clk;
  logic          rst;
  logic          ra_en, rb_en, we, pc_inc, mark;
  logic [IW-1:0] ra_id, rb_id, wr_id, mark_id;
  logic [DW-1:0] wr_dat;
  logic [DW-1:0] ra_dat, rb_dat, pc;
  logic          ra_vld, rb_vld;
  logic [RC-1:0] pend;

  int checks = 0;
  int passes = 0;

  logic [63:0] m_regs [RC];
  logic [31:0] m_pend;
  logic [63:0] m_ra_dat, m_rb_dat;
  logic        m_ra_vld, m_rb_vld;

  cpu_regfile_mp dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ra_en_i   (ra_en),
    .ra_id_i   (ra_id),
    .ra_dat_o  (ra_dat),
    .ra_vld_o  (ra_vld),
    .rb_en_i   (rb_en),
    .rb_id_i   (rb_id),
    .rb_dat_o  (rb_dat),
    .rb_vld_o  (rb_vld),
    .we_i      (we),
    .wr_id_i   (wr_id),
    .wr_dat_i  (wr_dat),
    .pc_o      (pc),
    .pc_inc_i  (pc_inc),
    .mark_i    (mark),
    .mark_id_i (mark_id),
    .pend_o    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read of register id returns, given the inputs of this cycle
  function automatic logic [63:0] model_read(input logic [IW-1:0] id);
    if (id == 0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr_id == id) return wr_dat;
    if (int'(id) == PCR && pc_inc && !(we && int'(wr_id) == PCR)) return m_regs[PCR] + 64'(STEP);
`endif
    return m_regs[id];
  endfunction

  // Advance the model by one clock using the currently driven inputs
  task automatic model_clock();
    logic [63:0] a_val, b_val;
    if (rst) begin
      for (int i = 0; i < RC; i++) m_regs[i] = 64'h0;
      m_regs[PCR] = PCRST;
      m_pend   = 32'h0;
      m_ra_dat = 64'h0;
      m_rb_dat = 64'h0;
      m_ra_vld = 1'b0;
      m_rb_vld = 1'b0;
    end else begin
      a_val = model_read(ra_id);
      b_val = model_read(rb_id);
      if (ra_en) m_ra_dat = a_val;
      if (rb_en) m_rb_dat = b_val;
      m_ra_vld = ra_en;
      m_rb_vld = rb_en;
      if (pc_inc) m_regs[PCR] = m_regs[PCR] + 64'(STEP);
      if (we && wr_id != 0) m_regs[wr_id] = wr_dat;
      if (we) m_pend[wr_id] = 1'b0;
      if (mark && mark_id != 0) m_pend[mark_id] = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    ra_en = 0; ra_id = 0; rb_en = 0; rb_id = 0;
    we = 0; wr_id = 0; wr_dat = 0;
    pc_inc = 0; mark = 0; mark_id = 0;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    checks++; if (pc !== PCRST) $display("[TB] FAIL reset_pc got %h want %h", pc, PCRST); else passes++;
    checks++; if (pend !== 32'h0) $display("[TB] FAIL reset_pend got %h want 0", pend); else passes++;
    checks++; if (ra_vld !== 1'b0) $display("[TB] FAIL reset_ra_vld got %b want 0", ra_vld); else passes++;
    checks++; if (rb_vld !== 1'b0) $display("[TB] FAIL reset_rb_vld got %b want 0", rb_vld); else passes++;
    checks++; if (ra_dat !== 64'h0) $display("[TB] FAIL reset_ra_dat got %h want 0", ra_dat); else passes++;
    ra_en = 1; ra_id = 5; rb_en = 1; rb_id = 31;
    step();
    clear_inputs();
    checks++; if (ra_dat !== 64'h0) $display("[TB] FAIL read_r5 got %h want 0", ra_dat); else passes++;
    checks++; if (rb_dat !== PCRST) $display("[TB] FAIL read_r31 got %h want %h", rb_dat, PCRST); else passes++;
    checks++; if (ra_vld !== 1'b1) $display("[TB] FAIL read_ra_vld got %b want 1", ra_vld); else passes++;
    checks++; if (rb_vld !== 1'b1) $display("[TB] FAIL read_rb_vld got %b want 1", rb_vld); else passes++;
    step();
    checks++; if (ra_vld !== 1'b0) $display("[TB] FAIL idle_ra_vld got %b want 0", ra_vld); else passes++;
    checks++; if (rb_dat !== PCRST) $display("[TB] FAIL idle_rb_hold got %h want %h", rb_dat, PCRST); else passes++;
  endtask

  task automatic test_write_read();
    we = 1; wr_id = 3; wr_dat = 64'hDEADBEEF;
    step();
    clear_inputs();
    ra_en = 1; ra_id = 3; rb_en = 1; rb_id = 3;
    step();
    clear_inputs();
    checks++; if (ra_dat !== 64'hDEADBEEF) $display("[TB] FAIL wr_r3_a got %h want deadbeef", ra_dat); else passes++;
    checks++; if (rb_dat !== 64'hDEADBEEF) $display("[TB] FAIL wr_r3_b got %h want deadbeef", rb_dat); else passes++;
    we = 1; wr_id = 0; wr_dat = 64'h1;
    step();
    clear_inputs();
    ra_en = 1; ra_id = 0;
    step();
    clear_inputs();
    checks++; if (ra_dat !== 64'h0) $display("[TB] FAIL r0_zero got %h want 0", ra_dat); else passes++;
  endtask

  task automatic test_pc();
    pc_inc = 1;
    step();
    checks++; if (pc !== PCRST + 64'h8) $display("[TB] FAIL pc_inc1 got %h want %h", pc, PCRST + 64'h8); else passes++;
    step();
    step();
    clear_inputs();
    checks++; if (pc !== 64'h800000000018) $display("[TB] FAIL pc_inc3 got %h want 800000000018", pc); else passes++;
    we = 1; wr_id = 31; wr_dat = 64'h1000; pc_inc = 1;
    step();
    clear_inputs();
    checks++; if (pc !== 64'h1000) $display("[TB] FAIL pc_jump got %h want 1000", pc); else passes++;
    we = 1; wr_id = 31; wr_dat = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_inputs();
    pc_inc = 1;
    step();
    clear_inputs();
    checks++; if (pc !== 64'h4) $display("[TB] FAIL pc_wrap got %h want 4", pc); else passes++;
  endtask

  task automatic test_read_during_write();
    logic [63:0] exp_val;
`ifdef REGFILE_BYPASS_EN
    exp_val = 64'h55;
`else
    exp_val = 64'h0;
`endif
    ra_en = 1; ra_id = 7; we = 1; wr_id = 7; wr_dat = 64'h55;
    step();
    clear_inputs();
    checks++; if (ra_dat !== exp_val) $display("[TB] FAIL rdw_r7 got %h want %h", ra_dat, exp_val); else passes++;
    rb_en = 1; rb_id = 7;
    step();
    clear_inputs();
    checks++; if (rb_dat !== 64'h55) $display("[TB] FAIL rdw_after got %h want 55", rb_dat); else passes++;
  endtask

  task automatic test_scoreboard();
    mark = 1; mark_id = 9;
    step();
    clear_inputs();
    checks++; if (pend[9] !== 1'b1) $display("[TB] FAIL mark_r9 got %b want 1", pend[9]); else passes++;
    we = 1; wr_id = 9; wr_dat = 64'h99; mark = 1; mark_id = 9;
    step();
    clear_inputs();
    checks++; if (pend[9] !== 1'b1) $display("[TB] FAIL mark_wins got %b want 1", pend[9]); else passes++;
    we = 1; wr_id = 9; wr_dat = 64'h9A;
    step();
    clear_inputs();
    checks++; if (pend[9] !== 1'b0) $display("[TB] FAIL write_clears got %b want 0", pend[9]); else passes++;
    mark = 1; mark_id = 0; pc_inc = 1;
    step();
    clear_inputs();
    checks++; if (pend !== 32'h0) $display("[TB] FAIL mark_r0 got %h want 0", pend); else passes++;
  endtask

  task automatic test_reset_mid_op();
    mark = 1; mark_id = 4; ra_en = 1; ra_id = 4;
    step();
    clear_inputs();
    checks++; if (pend[4] !== 1'b1) $display("[TB] FAIL mid_mark got %b want 1", pend[4]); else passes++;
    rst = 1; ra_en = 1; ra_id = 4; mark = 1; mark_id = 5; pc_inc = 1;
    we = 1; wr_id = 6; wr_dat = 64'h66;
    step();
    rst = 0;
    clear_inputs();
    checks++; if (pend !== 32'h0) $display("[TB] FAIL mid_pend got %h want 0", pend); else passes++;
    checks++; if (ra_vld !== 1'b0) $display("[TB] FAIL mid_vld got %b want 0", ra_vld); else passes++;
    checks++; if (pc !== PCRST) $display("[TB] FAIL mid_pc got %h want %h", pc, PCRST); else passes++;
  endtask

  function automatic logic [IW-1:0] pick_id();
    case ($urandom_range(0, 7))
      0: return 5'd0;
      1: return 5'd3;
      2: return 5'd7;
      3: return 5'd9;
      4: return 5'd31;
      default: return IW'($urandom_range(0, RC - 1));
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      ra_en   = 1'($urandom_range(0, 1));
      ra_id   = pick_id();
      rb_en   = 1'($urandom_range(0, 1));
      rb_id   = pick_id();
      we      = ($urandom_range(0, 2) != 0);
      wr_id   = pick_id();
      wr_dat  = {$urandom, $urandom};
      pc_inc  = ($urandom_range(0, 3) == 0);
      mark    = ($urandom_range(0, 3) == 0);
      mark_id = pick_id();
      step();
      checks++; if (ra_vld !== m_ra_vld) $display("[TB] FAIL rnd_ra_vld cyc %0d got %b want %b", n, ra_vld, m_ra_vld); else passes++;
      checks++; if (rb_vld !== m_rb_vld) $display("[TB] FAIL rnd_rb_vld cyc %0d got %b want %b", n, rb_vld, m_rb_vld); else passes++;
      checks++; if (ra_dat !== m_ra_dat) $display("[TB] FAIL rnd_ra_dat cyc %0d got %h want %h", n, ra_dat, m_ra_dat); else passes++;
      checks++; if (rb_dat !== m_rb_dat) $display("[TB] FAIL rnd_rb_dat cyc %0d got %h want %h", n, rb_dat, m_rb_dat); else passes++;
      checks++; if (pc !== m_regs[PCR]) $display("[TB] FAIL rnd_pc cyc %0d got %h want %h", n, pc, m_regs[PCR]); else passes++;
      checks++; if (pend !== m_pend) $display("[TB] FAIL rnd_pend cyc %0d got %h want %h", n, pend, m_pend); else passes++;
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    m_pend = 32'h0;
    for (int i = 0; i < RC; i++) m_regs[i] = 64'h0;
    m_ra_dat = 0; m_rb_dat = 0; m_ra_vld = 0; m_rb_vld = 0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_pc();
    test_read_during_write();
    test_scoreboard();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_regfile_mp.md
Name: cpu_regfile_mp

Overview:
Parametrised multi-port register file and successor to the single-port CPU register bank. It provides two independent registered read ports, one write port, a dedicated program-counter port with auto-increment, and a per-register pending-write scoreboard. With these, the CPU can fetch both operands of an RRO instruction in one cycle and track in-flight loads. It sits inside cpu, between the control FSM and the execute stage.

Parameters:
DAT_WIDTH, 64, register width in bits
REG_COUNT, 32, number of architectural registers; power of two, >= 4
PC_REG, 31, index of the program-counter register
PC_RESET, 64'h800000000000, PC value after reset (truncated to DAT_WIDTH)
PC_STEP, 8, byte increment applied by pc_inc_i
ID_W, $clog2(REG_COUNT), derived register-index width; do not override

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous reset, active-high
ra_en_i  in  1  read port A request
ra_id_i  in  ID_W  read port A register index
ra_dat_o  out  DAT_WIDTH  read port A data
ra_vld_o  out  1  read port A data valid
rb_en_i  in  1  read port B request
rb_id_i  in  ID_W  read port B register index
rb_dat_o  out  DAT_WIDTH  read port B data
rb_vld_o  out  1  read port B data valid
we_i  in  1  write enable
wr_id_i  in  ID_W  write register index
wr_dat_i  in  DAT_WIDTH  write data
pc_o  out  DAT_WIDTH  current PC, direct from register state (no read latency)
pc_inc_i  in  1  PC += PC_STEP
mark_i  in  1  set pending bit of mark_id_i
mark_id_i  in  ID_W  register to mark pending
pend_o  out  REG_COUNT  pending-write bitmap, bit n = register n

Behaviour:
- Reset (rst_i=1 at edge): all registers cleared to 0; PC_REG loaded with PC_RESET; ra/rb_dat_o=0; ra/rb_vld_o=0; pend_o=0. Reset wins over every other input.
- Reads: latency 1. With rx_en_i=1 at edge N, rx_dat_o holds regs[rx_id_i] and rx_vld_o=1 after edge N. With rx_en_i=0, rx_vld_o=0 and rx_dat_o holds its last value. Ports are fully independent; the same index on both ports is legal.
- Register 0 is hardwired zero: writes to index 0 are ignored, reads of index 0 always return 0, and marking index 0 is ignored.
- Write: with we_i=1, regs[wr_id_i] <= wr_dat_i. Reads and writes proceed simultaneously. Without bypass, a read of the index being written in the same cycle returns the old value.
- PC port: pc_o = regs[PC_REG] at all times. pc_inc_i=1 gives PC <= PC + PC_STEP, modulo 2^DAT_WIDTH (wraps silently).
- PC conflict: if we_i=1 with wr_id_i=PC_REG and pc_inc_i=1 in the same cycle, the explicit write wins (jump beats increment) and the increment is dropped.
- Scoreboard: mark_i sets pend[mark_id_i]. A write with we_i=1 clears pend[wr_id_i].
- Scoreboard conflict: mark and write to the same index in one cycle leaves pend set (mark wins; it marks a new in-flight write). pc_inc_i does not affect pend.
- Reset mid-operation: any in-flight read valid is dropped (vld=0 next cycle) and all pending bits are cleared.
- Out-of-range indices (only possible when REG_COUNT is not a power of two) are illegal; REG_COUNT is constrained to powers of two.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If rx_en_i=1, we_i=1, rx_id_i=wr_id_i and the index is non-zero, rx_dat_o returns wr_dat_i next cycle. Likewise, a read of PC_REG during pc_inc_i (with no explicit PC write) returns PC+PC_STEP.
- Undefined: reads return the pre-write value, as stated under Behaviour. Latency is 1 in both cases.

Test Plan:
1. Reset -> pc_o=64'h800000000000, pend_o=0, ra_vld_o=0. Then read r5 on A and r31 on B -> next cycle A=0, B=64'h800000000000, both vld=1.
2. Write r3=64'hDEADBEEF, then read r3 on both ports -> both return 64'hDEADBEEF. Write r0=64'h1, then read r0 -> 0.
3. pc_inc_i for 3 cycles -> pc_o=64'h800000000018. Same cycle: we_i to r31 = 64'h1000 plus pc_inc_i -> pc_o=64'h1000 (not 64'h1008).
4. Read r7 and write r7=64'h55 in the same cycle -> ra_dat_o=old value (0) without REGFILE_BYPASS_EN, 64'h55 with it.
5. mark r9 -> pend_o[9]=1. Write r9 with mark r9 in the same cycle -> pend_o[9] stays 1. A later write r9 alone -> pend_o[9]=0.
6. Mark r4, issue ra_en_i, assert rst_i in the next cycle -> pend_o=0, ra_vld_o=0, pc_o=PC_RESET.
